// File: rtl/sy_rst_pkg.sv
// Shared types and sizing helper for the reset sequencer slice.
package sy_rst_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      ASSERT  = 2'd3
   } rst_state_e;

   typedef enum logic [1:0] {
      CAUSE_POR = 2'd0,
      CAUSE_SW  = 2'd1,
      CAUSE_WDT = 2'd2
   } rst_cause_e;

   // Wide enough to hold the last release offset plus the done cycle.
   function automatic int seq_cnt_w(input int hold_cyc, input int num_ch, input int stagger);
      return $clog2(hold_cyc + num_ch * stagger + 1);
   endfunction

endpackage

// File: rtl/sy_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES clock edges.
module sy_rst_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   output logic srst_n
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sy_rst_seq.sv
// Staggered channel reset sequencer with boot watchdog, warm-reset cause and count.
module sy_rst_seq
   import sy_rst_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int HOLD_CYC    = 8,
   parameter int STAGGER     = 16,
   parameter int SYNC_STAGES = 2,
   parameter int WDT_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sw_rst_req_i,
   input  logic              boot_done_i,
   input  logic [WDT_W-1:0]  wdt_limit_i,
   output logic [NUM_CH-1:0] ch_rst_no,
   output logic              rst_done_o,
   output logic              wdt_expire_o,
   output logic [1:0]        rst_cause_o,
   output logic [7:0]        rst_cnt_o
);

   localparam int CNT_W = seq_cnt_w(HOLD_CYC, NUM_CH, STAGGER);
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] SEQ_END  = CNT_W'(HOLD_CYC + (NUM_CH - 1) * STAGGER + 1);

   logic              srst_n;
   rst_state_e        state_q, state_d;
   logic [CNT_W-1:0]  seq_q, seq_d;
   logic [WDT_W-1:0]  wdt_q, wdt_d;
   logic              boot_q, boot_d;
   logic [NUM_CH-1:0] ch_d;
   logic              done_d, exp_d;
   rst_cause_e        cause_q, cause_d;
   logic [7:0]        cnt_d;
   logic              wdt_run, wdt_hit, warm;

   sy_rst_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk_i),
      .arst_n (rst_i),
      .srst_n (srst_n)
   );

   // A pending expiry pulse is itself the watchdog trigger on the following edge.
   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      wdt_d   = wdt_q;
      boot_d  = boot_q | boot_done_i;
      ch_d    = ch_rst_no;
      done_d  = rst_done_o;
      exp_d   = 1'b0;
      cause_d = cause_q;
      cnt_d   = rst_cnt_o;
      wdt_run = (state_q == RUN) && !boot_q && (wdt_limit_i != '0) && !wdt_expire_o;
      wdt_hit = wdt_run && ((wdt_q + WDT_W'(1)) == wdt_limit_i);
      warm    = (state_q != ASSERT) && (sw_rst_req_i || wdt_expire_o);

      case (state_q)
         HOLD, RELEASE: begin
            seq_d = seq_q + CNT_W'(1);
            for (int k = 0; k < NUM_CH; k++) begin
               ch_d[k] = (seq_q >= CNT_W'(HOLD_CYC + k * STAGGER));
            end
            if (state_q == HOLD && seq_q == HOLD_END) begin
               state_d = RELEASE;
            end
            if (state_q == RELEASE && seq_q == SEQ_END) begin
               state_d = RUN;
               seq_d   = seq_q;
               done_d  = 1'b1;
               wdt_d   = '0;
            end
         end
         RUN: begin
            if (wdt_run) begin
               wdt_d = wdt_q + WDT_W'(1);
            end
            exp_d = wdt_hit;
         end
         ASSERT: begin
            state_d = HOLD;
            seq_d   = seq_q + CNT_W'(1);
         end
         default: begin
            state_d = HOLD;
         end
      endcase

      if (warm) begin
         state_d = ASSERT;
         ch_d    = '0;
         done_d  = 1'b0;
         seq_d   = '0;
         wdt_d   = '0;
         boot_d  = 1'b0;
         cause_d = (wdt_expire_o || wdt_hit) ? CAUSE_WDT : CAUSE_SW;
         cnt_d   = (rst_cnt_o == 8'hFF) ? rst_cnt_o : rst_cnt_o + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge srst_n) begin
      if (!srst_n) begin
         state_q      <= HOLD;
         seq_q        <= '0;
         wdt_q        <= '0;
         boot_q       <= 1'b0;
         ch_rst_no    <= '0;
         rst_done_o   <= 1'b0;
         wdt_expire_o <= 1'b0;
         cause_q      <= CAUSE_POR;
         rst_cnt_o    <= 8'd0;
      end else begin
         state_q      <= state_d;
         seq_q        <= seq_d;
         wdt_q        <= wdt_d;
         boot_q       <= boot_d;
         ch_rst_no    <= ch_d;
         rst_done_o   <= done_d;
         wdt_expire_o <= exp_d;
         cause_q      <= cause_d;
         rst_cnt_o    <= cnt_d;
      end
   end

   assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_sy_rst_seq.sv
// Directed bench for sy_rst_seq with default parameters; cycle 0 is each sequence reference edge.
module tb_sy_rst_seq;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sw_rst_req_i;
   logic        boot_done_i;
   logic [31:0] wdt_limit_i;
   logic [3:0]  ch_rst_no;
   logic        rst_done_o;
   logic        wdt_expire_o;
   logic [1:0]  rst_cause_o;
   logic [7:0]  rst_cnt_o;

   int cyc;
   int n_cmp;
   int n_fail;
   int exp_seen;

   sy_rst_seq dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .sw_rst_req_i (sw_rst_req_i),
      .boot_done_i  (boot_done_i),
      .wdt_limit_i  (wdt_limit_i),
      .ch_rst_no    (ch_rst_no),
      .rst_done_o   (rst_done_o),
      .wdt_expire_o (wdt_expire_o),
      .rst_cause_o  (rst_cause_o),
      .rst_cnt_o    (rst_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   // Two synchroniser edges pass, so the next edge is cycle 0.
   task automatic por_release();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      cyc = -1;
   endtask

   task automatic check_seq(input string tag);
      goto(7);  check({tag, "_c7_ch"},  ch_rst_no, 4'b0000);
      goto(8);  check({tag, "_c8_ch"},  ch_rst_no, 4'b0001);
      goto(23); check({tag, "_c23_ch"}, ch_rst_no, 4'b0001);
      goto(24); check({tag, "_c24_ch"}, ch_rst_no, 4'b0011);
      goto(40); check({tag, "_c40_ch"}, ch_rst_no, 4'b0111);
      goto(56); check({tag, "_c56_ch"}, ch_rst_no, 4'b1111);
      check({tag, "_c56_done"}, rst_done_o, 1'b0);
      goto(57); check({tag, "_c57_done"}, rst_done_o, 1'b1);
   endtask

   initial begin
      rst_i        = 1'b0;
      sw_rst_req_i = 1'b0;
      boot_done_i  = 1'b0;
      wdt_limit_i  = 32'd100;
      cyc          = 0;
      n_cmp        = 0;
      n_fail       = 0;
      exp_seen     = 0;
      $display("[TB] start");

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ch", ch_rst_no, 4'b0000);
      check("rst_done", rst_done_o, 1'b0);
      check("rst_exp", wdt_expire_o, 1'b0);
      check("rst_cause", rst_cause_o, 2'd0);
      check("rst_cnt", rst_cnt_o, 8'd0);

      por_release();
      check_seq("por");
      check("por_cause", rst_cause_o, 2'd0);
      check("por_cnt", rst_cnt_o, 8'd0);

      goto(156); check("wdt_c156_exp", wdt_expire_o, 1'b0);
      goto(157); check("wdt_c157_exp", wdt_expire_o, 1'b1);
      check("wdt_c157_ch", ch_rst_no, 4'b1111);
      goto(158); check("wdt_c158_exp", wdt_expire_o, 1'b0);
      check("wdt_c158_ch", ch_rst_no, 4'b0000);
      check("wdt_c158_done", rst_done_o, 1'b0);
      check("wdt_cause", rst_cause_o, 2'd2);
      check("wdt_cnt", rst_cnt_o, 8'd1);
      goto(159);
      cyc = 0;
      check_seq("rep");

      goto(60);
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      check("swrun_ch", ch_rst_no, 4'b0000);
      check("swrun_cause", rst_cause_o, 2'd1);
      check("swrun_cnt", rst_cnt_o, 8'd2);
      tick();
      cyc = 0;

      goto(57);  check("both_done", rst_done_o, 1'b1);
      goto(157); check("both_exp", wdt_expire_o, 1'b1);
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      check("both_cause", rst_cause_o, 2'd2);
      check("both_cnt", rst_cnt_o, 8'd3);
      check("both_exp_low", wdt_expire_o, 1'b0);
      check("both_ch", ch_rst_no, 4'b0000);
      tick();
      cyc = 0;

      goto(107);
      boot_done_i = 1'b1;
      tick();
      boot_done_i = 1'b0;
      exp_seen = 0;
      repeat (10000) begin
         tick();
         if (wdt_expire_o) exp_seen++;
      end
      check("boot_no_expire", exp_seen, 0);
      check("boot_done_held", rst_done_o, 1'b1);

      wdt_limit_i  = 32'd0;
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      check("sw4_cause", rst_cause_o, 2'd1);
      check("sw4_cnt", rst_cnt_o, 8'd4);
      tick();
      cyc = 0;
      goto(57); check("lim0_done", rst_done_o, 1'b1);
      exp_seen = 0;
      repeat (10000) begin
         tick();
         if (wdt_expire_o) exp_seen++;
      end
      check("lim0_no_expire", exp_seen, 0);
      check("lim0_done_held", rst_done_o, 1'b1);

      #2;
      rst_i = 1'b0;
      #1;
      check("async_ch", ch_rst_no, 4'b0000);
      check("async_done", rst_done_o, 1'b0);
      check("async_cause", rst_cause_o, 2'd0);
      check("async_cnt", rst_cnt_o, 8'd0);

      wdt_limit_i = 32'd100;
      por_release();
      goto(24); check("rel_c24_ch", ch_rst_no, 4'b0011);
      check("rel_cause", rst_cause_o, 2'd0);
      goto(30); check("rel_c30_ch", ch_rst_no, 4'b0011);
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      check("rel_c31_ch", ch_rst_no, 4'b0000);
      check("rel_c31_done", rst_done_o, 1'b0);
      check("rel_cause_sw", rst_cause_o, 2'd1);
      check("rel_cnt", rst_cnt_o, 8'd1);
      goto(39); check("rel_c39_ch", ch_rst_no, 4'b0000);
      goto(40); check("rel_c40_ch", ch_rst_no, 4'b0001);

      sw_rst_req_i = 1'b1;
      repeat (600) tick();
      sw_rst_req_i = 1'b0;
      repeat (3) tick();
      check("sat_cnt", rst_cnt_o, 8'd255);
      check("sat_cause", rst_cause_o, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
